cache_fsm_l2d: RTL and testbench
================================

// Module: cache_fsm_L2d
// PURPOSE
// - Direct-mapped, write-back, write-allocate L2 data cache controller.
// - Sits directly downstream of the L1d controller and serves its three request types:
//   line read, word write (inclusion), and dirty-line write-back.
// - Misses and dirty evictions go to the L3d level through a request/verify handshake.
// PARAMETERS
// - ADDRESS_WIDTH       32   byte address width, including processor-ID bits
// - DATA_WIDTH          32   processor word width
// - LINE_WIDTH          128  cache line width (= MAIN_MEMORY_DATA_WIDTH)
// - L2_NUM_SETS         64   number of lines; power of 2
// - PROCESSOR_ID_WIDTH  2    top address bits; not part of the tag
// PORTS
// - clk                          in   1     clock, rising edge
// - reset                        in   1     asynchronous, active-low reset
// - read_from_L2d_request        in   1     L1d line read; level, held until L2d_ready
// - write_to_L2d_request         in   1     L1d word write; held until write_to_L2d_verified
// - write_back_to_L2d_request    in   1     L1d line write-back; held until write_back_to_L2d_verified
// - cache_L2d_memory_address     in   AW    address of the request
// - cache_1d_write_data_to_L2d   in   DW    word for a word write
// - write_back_to_L2d_data       in   LW    line for a write-back
// - L2d_ready                    out  1     1-cycle pulse; read data valid
// - write_data_to_L1d_from_L2d   out  LW    read line; held until next read response
// - write_to_L2d_verified        out  1     1-cycle pulse; word write done
// - write_back_to_L2d_verified   out  1     1-cycle pulse; write-back done
// - L2d_cache_hit                out  1     1-cycle pulse in COMPARE on hit
// - L2d_cache_miss               out  1     1-cycle pulse in COMPARE on miss
// - read_from_L3d_request        out  1     L3 line fetch; held until L3d_ready
// - write_back_to_L3d_request    out  1     L3 eviction; held until write_back_to_L3d_verified
// - cache_L3d_memory_address     out  AW    line address to L3, offset bits zero
// - write_back_to_L3d_data       out  LW    evicted line
// - L3d_ready                    in   1     pulse; write_data_to_L2d_from_L3d valid
// - write_data_to_L2d_from_L3d   in   LW    fetched line
// - write_back_to_L3d_verified   in   1     pulse; eviction accepted
// BEHAVIOUR
// - Address split (OW = log2(LW/DW), IW = log2(L2_NUM_SETS)):
//   - word offset = addr[OW+1:2]
//   - index = addr[IW+OW+1:OW+2]
//   - tag = addr[AW-PROCESSOR_ID_WIDTH-1:IW+OW+2]
//   - Byte bits [1:0] and processor-ID bits are ignored.
// - Storage per line: valid, dirty, tag, LW data. Reset clears valid and dirty only.
// - Reset (reset=0, async): state to IDLE, all outputs 0, armed flag cleared to 1.
//   - Reset mid-transaction abandons the transaction; no L3 request survives.
// - States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND.
// - IDLE:
//   - Accepts a request only when armed and at least one request input is high.
//   - Priority: write-back > word write > read.
//   - Latches the type, address, word and line, clears armed, then goes to COMPARE.
//   - Re-arms after seeing all three request inputs low for one cycle, so a held request
//     is never serviced twice.
// - COMPARE:
//   - Hit means valid and tag match. Pulses hit or miss.
//   - Hit, read: go to RESPOND with the line.
//   - Hit, word write: merge the word at the offset, set dirty, go to RESPOND.
//   - Hit, write-back: overwrite the line, set dirty, go to RESPOND.
//   - Miss with victim valid and dirty: go to WRITE_BACK.
//   - Miss with victim clean or invalid: write-back requests install directly
//     (tag, valid=1, dirty=1, line) and go to RESPOND; all others go to ALLOCATE.
// - WRITE_BACK:
//   - Drives write_back_to_L3d_request, the victim address {tag, index, 0} and the victim data.
//   - On write_back_to_L3d_verified: clear dirty, drop the request the next cycle, then
//     install the line (write-back type, as above) or go to ALLOCATE.
// - ALLOCATE:
//   - Drives read_from_L3d_request with the line address.
//   - On L3d_ready: install the fetched line (valid=1, dirty=0, tag).
//   - If the request is a word write, merge the word into that installed line and set dirty.
//   - Then go to RESPOND.
// - RESPOND:
//   - Pulses exactly one of L2d_ready, write_to_L2d_verified or write_back_to_L2d_verified.
//   - For a read, updates write_data_to_L1d_from_L2d.
//   - Then goes to IDLE.
// - Latency from the accept cycle (cycle 0):
//   - Any hit: response in cycle 2.
//   - Clean miss: response 2 cycles after L3d_ready.
//   - L3 handshake signals arriving outside their waiting state are ignored.
// - Simultaneous events:
//   - Request inputs changing after accept are ignored until re-armed.
//   - Reset beats any concurrent L3 pulse.
// TESTING
// - Reset, then read 0xC000_0010 (cold):
//   -> miss pulse, read_from_L3d_request with address 0xC000_0010.
//   -> L3d_ready with 0xDDDD_CCCC_BBBB_AAAA... -> L2d_ready 2 cycles later, same line out.
// - Repeat the same read -> hit pulse, L2d_ready in cycle 2, no L3 request.
// - Word write 0x1234_5678 to 0xC000_0014 after fill:
//   -> hit, write_to_L2d_verified in cycle 2.
//   -> Re-read returns the line with word 1 = 0x1234_5678.
// - Read 0xC000_0410 (same index, new tag) with the dirty line present:
//   -> write_back_to_L3d_request with address 0xC000_0010 and the merged data.
//   -> Then an L3 fetch, then L2d_ready.
// - Write-back and read requests high together in IDLE:
//   -> write-back is serviced first.
//   -> Held requests do not retrigger until all inputs drop for one cycle.
// - Assert reset during ALLOCATE:
//   -> all outputs 0 immediately, L3 request drops.
//   -> A re-read of the same address misses.

Source files
------------

// File: rtl/cache_fsm_l2d.sv
// Direct-mapped, write-back, write-allocate L2 data cache controller.
// Serves L1d line reads, word writes and line write-backs; misses and dirty evictions go to L3d.
module cache_fsm_l2d #(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int LINE_WIDTH         = 128,
  parameter int L2_NUM_SETS        = 64,
  parameter int PROCESSOR_ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_from_L2d_request,
  input  logic                     write_to_L2d_request,
  input  logic                     write_back_to_L2d_request,
  input  logic [ADDRESS_WIDTH-1:0] cache_L2d_memory_address,
  input  logic [DATA_WIDTH-1:0]    cache_1d_write_data_to_L2d,
  input  logic [LINE_WIDTH-1:0]    write_back_to_L2d_data,
  output logic                     L2d_ready,
  output logic [LINE_WIDTH-1:0]    write_data_to_L1d_from_L2d,
  output logic                     write_to_L2d_verified,
  output logic                     write_back_to_L2d_verified,
  output logic                     L2d_cache_hit,
  output logic                     L2d_cache_miss,
  output logic                     read_from_L3d_request,
  output logic                     write_back_to_L3d_request,
  output logic [ADDRESS_WIDTH-1:0] cache_L3d_memory_address,
  output logic [LINE_WIDTH-1:0]    write_back_to_L3d_data,
  input  logic                     L3d_ready,
  input  logic [LINE_WIDTH-1:0]    write_data_to_L2d_from_L3d,
  input  logic                     write_back_to_L3d_verified
);

  localparam int WPL = LINE_WIDTH / DATA_WIDTH;
  localparam int OW  = $clog2(WPL);
  localparam int IW  = $clog2(L2_NUM_SETS);
  localparam int TLO = IW + OW + 2;
  localparam int TW  = ADDRESS_WIDTH - PROCESSOR_ID_WIDTH - TLO;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_WRITE_BACK = 3'd2,
    S_ALLOCATE   = 3'd3,
    S_RESPOND    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RQ_READ = 2'd0,
    RQ_WORD = 2'd1,
    RQ_LINE = 2'd2
  } req_t;

  state_t                  state_r;
  req_t                    req_type_r;
  logic                    armed_r;
  logic                    hit_r;
  logic                    fill_done_r;
  logic [ADDRESS_WIDTH-1:0] req_addr_r;
  logic [DATA_WIDTH-1:0]   req_word_r;
  logic [LINE_WIDTH-1:0]   req_line_r;
  logic [LINE_WIDTH-1:0]   fill_line_r;
  logic [L2_NUM_SETS-1:0]  valid_r;
  logic [L2_NUM_SETS-1:0]  dirty_r;
  logic [TW-1:0]           tag_r  [L2_NUM_SETS];
  logic [LINE_WIDTH-1:0]   data_r [L2_NUM_SETS];

  logic                    any_req_s;
  logic [IW-1:0]           in_idx_s;
  logic [TW-1:0]           in_tag_s;
  logic                    in_hit_s;
  logic [IW-1:0]           req_idx_s;
  logic [TW-1:0]           req_tag_s;
  logic [OW-1:0]           req_off_s;
  logic [PROCESSOR_ID_WIDTH-1:0] req_pid_s;
  logic [LINE_WIDTH-1:0]   cur_line_s;
  logic                    victim_dirty_s;
  logic [ADDRESS_WIDTH-1:0] line_addr_s;
  logic [ADDRESS_WIDTH-1:0] victim_addr_s;
  logic                    arr_we_s;
  logic [LINE_WIDTH-1:0]   arr_line_s;
  logic                    unused_s;

  function automatic logic [LINE_WIDTH-1:0] merge_word(
    input logic [LINE_WIDTH-1:0] line,
    input logic [OW-1:0]         off,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [LINE_WIDTH-1:0] merged;
    merged = line;
    for (int w = 0; w < WPL; w++) begin
      if (OW'(w) == off) merged[w*DATA_WIDTH +: DATA_WIDTH] = word;
    end
    return merged;
  endfunction

  assign any_req_s      = read_from_L2d_request | write_to_L2d_request | write_back_to_L2d_request;
  assign in_idx_s       = cache_L2d_memory_address[TLO-1:OW+2];
  assign in_tag_s       = cache_L2d_memory_address[ADDRESS_WIDTH-PROCESSOR_ID_WIDTH-1:TLO];
  assign in_hit_s       = valid_r[in_idx_s] && (tag_r[in_idx_s] == in_tag_s);
  assign req_idx_s      = req_addr_r[TLO-1:OW+2];
  assign req_tag_s      = req_addr_r[ADDRESS_WIDTH-PROCESSOR_ID_WIDTH-1:TLO];
  assign req_off_s      = req_addr_r[OW+1:2];
  assign req_pid_s      = req_addr_r[ADDRESS_WIDTH-1:ADDRESS_WIDTH-PROCESSOR_ID_WIDTH];
  assign cur_line_s     = data_r[req_idx_s];
  assign victim_dirty_s = valid_r[req_idx_s] & dirty_r[req_idx_s];
  assign line_addr_s    = {req_addr_r[ADDRESS_WIDTH-1:OW+2], {(OW+2){1'b0}}};
  // Victim keeps the requester's processor-ID bits; only tag and index identify the line.
  assign victim_addr_s  = {req_pid_s, tag_r[req_idx_s], req_idx_s, {(OW+2){1'b0}}};
  assign unused_s       = ^req_addr_r[1:0];

  // Select whether and what to write into the tag/data arrays this cycle
  always_comb begin
    arr_we_s   = 1'b0;
    arr_line_s = cur_line_s;
    case (state_r)
      S_COMPARE: begin
        if (hit_r && (req_type_r == RQ_WORD)) begin
          arr_we_s   = 1'b1;
          arr_line_s = merge_word(cur_line_s, req_off_s, req_word_r);
        end else if ((req_type_r == RQ_LINE) && (hit_r || !victim_dirty_s)) begin
          arr_we_s   = 1'b1;
          arr_line_s = req_line_r;
        end else begin
          arr_we_s   = 1'b0;
          arr_line_s = cur_line_s;
        end
      end
      S_WRITE_BACK: begin
        if (write_back_to_L3d_verified && (req_type_r == RQ_LINE)) begin
          arr_we_s   = 1'b1;
          arr_line_s = req_line_r;
        end else begin
          arr_we_s   = 1'b0;
          arr_line_s = cur_line_s;
        end
      end
      S_ALLOCATE: begin
        if (fill_done_r) begin
          arr_we_s   = 1'b1;
          arr_line_s = (req_type_r == RQ_WORD) ? merge_word(fill_line_r, req_off_s, req_word_r)
                                               : fill_line_r;
        end else begin
          arr_we_s   = 1'b0;
          arr_line_s = cur_line_s;
        end
      end
      default: begin
        arr_we_s   = 1'b0;
        arr_line_s = cur_line_s;
      end
    endcase
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      data_r[req_idx_s] <= arr_line_s;
      tag_r[req_idx_s]  <= req_tag_s;
    end
  end

  // Request sequencing, line state bits and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r                    <= S_IDLE;
      req_type_r                 <= RQ_READ;
      armed_r                    <= 1'b1;
      hit_r                      <= 1'b0;
      fill_done_r                <= 1'b0;
      req_addr_r                 <= {ADDRESS_WIDTH{1'b0}};
      req_word_r                 <= {DATA_WIDTH{1'b0}};
      req_line_r                 <= {LINE_WIDTH{1'b0}};
      fill_line_r                <= {LINE_WIDTH{1'b0}};
      valid_r                    <= {L2_NUM_SETS{1'b0}};
      dirty_r                    <= {L2_NUM_SETS{1'b0}};
      L2d_ready                  <= 1'b0;
      write_data_to_L1d_from_L2d <= {LINE_WIDTH{1'b0}};
      write_to_L2d_verified      <= 1'b0;
      write_back_to_L2d_verified <= 1'b0;
      L2d_cache_hit              <= 1'b0;
      L2d_cache_miss             <= 1'b0;
      read_from_L3d_request      <= 1'b0;
      write_back_to_L3d_request  <= 1'b0;
      cache_L3d_memory_address   <= {ADDRESS_WIDTH{1'b0}};
      write_back_to_L3d_data     <= {LINE_WIDTH{1'b0}};
    end else begin
      L2d_ready                  <= 1'b0;
      write_to_L2d_verified      <= 1'b0;
      write_back_to_L2d_verified <= 1'b0;
      L2d_cache_hit              <= 1'b0;
      L2d_cache_miss             <= 1'b0;
      // A held request must fall before the next one is taken
      if (!any_req_s) armed_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (armed_r && any_req_s) begin
            armed_r <= 1'b0;
            if (write_back_to_L2d_request)  req_type_r <= RQ_LINE;
            else if (write_to_L2d_request)  req_type_r <= RQ_WORD;
            else                            req_type_r <= RQ_READ;
            req_addr_r     <= cache_L2d_memory_address;
            req_word_r     <= cache_1d_write_data_to_L2d;
            req_line_r     <= write_back_to_L2d_data;
            hit_r          <= in_hit_s;
            L2d_cache_hit  <= in_hit_s;
            L2d_cache_miss <= !in_hit_s;
            state_r        <= S_COMPARE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_COMPARE: begin
          if (hit_r) begin
            if (req_type_r != RQ_READ) dirty_r[req_idx_s] <= 1'b1;
            if (req_type_r == RQ_READ) write_data_to_L1d_from_L2d <= cur_line_s;
            L2d_ready                  <= (req_type_r == RQ_READ);
            write_to_L2d_verified      <= (req_type_r == RQ_WORD);
            write_back_to_L2d_verified <= (req_type_r == RQ_LINE);
            state_r                    <= S_RESPOND;
          end else if (victim_dirty_s) begin
            write_back_to_L3d_request <= 1'b1;
            cache_L3d_memory_address  <= victim_addr_s;
            write_back_to_L3d_data    <= cur_line_s;
            state_r                   <= S_WRITE_BACK;
          end else if (req_type_r == RQ_LINE) begin
            valid_r[req_idx_s]         <= 1'b1;
            dirty_r[req_idx_s]         <= 1'b1;
            write_back_to_L2d_verified <= 1'b1;
            state_r                    <= S_RESPOND;
          end else begin
            read_from_L3d_request    <= 1'b1;
            cache_L3d_memory_address <= line_addr_s;
            fill_done_r              <= 1'b0;
            state_r                  <= S_ALLOCATE;
          end
        end
        S_WRITE_BACK: begin
          if (write_back_to_L3d_verified) begin
            write_back_to_L3d_request <= 1'b0;
            if (req_type_r == RQ_LINE) begin
              valid_r[req_idx_s]         <= 1'b1;
              dirty_r[req_idx_s]         <= 1'b1;
              write_back_to_L2d_verified <= 1'b1;
              state_r                    <= S_RESPOND;
            end else begin
              dirty_r[req_idx_s]       <= 1'b0;
              read_from_L3d_request    <= 1'b1;
              cache_L3d_memory_address <= line_addr_s;
              fill_done_r              <= 1'b0;
              state_r                  <= S_ALLOCATE;
            end
          end else begin
            state_r <= S_WRITE_BACK;
          end
        end
        S_ALLOCATE: begin
          // The fetched line is captured first and installed on the following cycle
          if (fill_done_r) begin
            valid_r[req_idx_s]    <= 1'b1;
            dirty_r[req_idx_s]    <= (req_type_r == RQ_WORD);
            fill_done_r           <= 1'b0;
            L2d_ready             <= (req_type_r == RQ_READ);
            write_to_L2d_verified <= (req_type_r == RQ_WORD);
            if (req_type_r == RQ_READ) write_data_to_L1d_from_L2d <= fill_line_r;
            state_r               <= S_RESPOND;
          end else if (L3d_ready) begin
            fill_line_r           <= write_data_to_L2d_from_L3d;
            fill_done_r           <= 1'b1;
            read_from_L3d_request <= 1'b0;
          end else begin
            state_r <= S_ALLOCATE;
          end
        end
        S_RESPOND: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fsm_l2d.sv
// Directed bench for cache_fsm_l2d: a per-cycle vector table for the fill/hit/write flow,
// then hand-written sequences for eviction, request priority, write-back install and reset.
module tb_cache_fsm_l2d;

  logic         clk = 1'b0;
  logic         reset;
  logic         read_from_L2d_request;
  logic         write_to_L2d_request;
  logic         write_back_to_L2d_request;
  logic [31:0]  cache_L2d_memory_address;
  logic [31:0]  cache_1d_write_data_to_L2d;
  logic [127:0] write_back_to_L2d_data;
  logic         L2d_ready;
  logic [127:0] write_data_to_L1d_from_L2d;
  logic         write_to_L2d_verified;
  logic         write_back_to_L2d_verified;
  logic         L2d_cache_hit;
  logic         L2d_cache_miss;
  logic         read_from_L3d_request;
  logic         write_back_to_L3d_request;
  logic [31:0]  cache_L3d_memory_address;
  logic [127:0] write_back_to_L3d_data;
  logic         L3d_ready;
  logic [127:0] write_data_to_L2d_from_L3d;
  logic         write_back_to_L3d_verified;

  cache_fsm_l2d dut (
    .clk                        (clk),
    .reset                      (reset),
    .read_from_L2d_request      (read_from_L2d_request),
    .write_to_L2d_request       (write_to_L2d_request),
    .write_back_to_L2d_request  (write_back_to_L2d_request),
    .cache_L2d_memory_address   (cache_L2d_memory_address),
    .cache_1d_write_data_to_L2d (cache_1d_write_data_to_L2d),
    .write_back_to_L2d_data     (write_back_to_L2d_data),
    .L2d_ready                  (L2d_ready),
    .write_data_to_L1d_from_L2d (write_data_to_L1d_from_L2d),
    .write_to_L2d_verified      (write_to_L2d_verified),
    .write_back_to_L2d_verified (write_back_to_L2d_verified),
    .L2d_cache_hit              (L2d_cache_hit),
    .L2d_cache_miss             (L2d_cache_miss),
    .read_from_L3d_request      (read_from_L3d_request),
    .write_back_to_L3d_request  (write_back_to_L3d_request),
    .cache_L3d_memory_address   (cache_L3d_memory_address),
    .write_back_to_L3d_data     (write_back_to_L3d_data),
    .L3d_ready                  (L3d_ready),
    .write_data_to_L2d_from_L3d (write_data_to_L2d_from_L3d),
    .write_back_to_L3d_verified (write_back_to_L3d_verified)
  );

  always #5 clk = ~clk;

  // Output flag order: {L2d_ready, wr_verified, wb_verified, hit, miss, rd_L3, wb_L3}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_RDY  = 7'b1000000;
  localparam logic [6:0] F_WV   = 7'b0100000;
  localparam logic [6:0] F_WBV  = 7'b0010000;
  localparam logic [6:0] F_HIT  = 7'b0001000;
  localparam logic [6:0] F_MISS = 7'b0000100;
  localparam logic [6:0] F_RL3  = 7'b0000010;
  localparam logic [6:0] F_WL3  = 7'b0000001;

  localparam logic [31:0] A10  = 32'hC000_0010;
  localparam logic [31:0] A14  = 32'hC000_0014;
  localparam logic [31:0] A30  = 32'hC000_0030;
  localparam logic [31:0] A410 = 32'hC000_0410;
  localparam logic [31:0] A820 = 32'hC000_0820;
  localparam logic [31:0] WD   = 32'h1234_5678;

  localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_B = 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA;
  localparam logic [127:0] LINE_C = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] LINE_D = 128'h44444444_55555555_66666666_77777777;
  localparam logic [127:0] LINE_E = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         l3r;
    logic [6:0]   flags;
    logic         ca;
    logic [31:0]  eaddr;
    logic         cl;
    logic [127:0] eline;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [19];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic l3r, input logic [6:0] flags,
                              input logic ca, input logic [31:0] eaddr,
                              input logic cl, input logic [127:0] eline);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.l3r = l3r;
    v.flags = flags; v.ca = ca; v.eaddr = eaddr; v.cl = cl; v.eline = eline;
    return v;
  endfunction

  function automatic logic [6:0] flags_now();
    return {L2d_ready, write_to_L2d_verified, write_back_to_L2d_verified,
            L2d_cache_hit, L2d_cache_miss, read_from_L3d_request, write_back_to_L3d_request};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    chk(name, 128'(flags_now()), 128'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[1]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_MISS, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[2]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_RL3,  1'b1, A10,   1'b0, 128'h0);
    tbl[3]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b1, F_RL3,  1'b1, A10,   1'b0, 128'h0);
    tbl[4]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[5]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_RDY,  1'b0, 32'h0, 1'b1, LINE_A);
    tbl[6]  = mk(1'b0, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b1, LINE_A);
    tbl[7]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[8]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_HIT,  1'b0, 32'h0, 1'b0, 128'h0);
    tbl[9]  = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_RDY,  1'b0, 32'h0, 1'b1, LINE_A);
    tbl[10] = mk(1'b0, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[11] = mk(1'b0, 1'b1, A14, WD,    1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[12] = mk(1'b0, 1'b1, A14, WD,    1'b0, F_HIT,  1'b0, 32'h0, 1'b0, 128'h0);
    tbl[13] = mk(1'b0, 1'b1, A14, WD,    1'b0, F_WV,   1'b0, 32'h0, 1'b0, 128'h0);
    tbl[14] = mk(1'b0, 1'b0, A14, WD,    1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[15] = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);
    tbl[16] = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_HIT,  1'b0, 32'h0, 1'b0, 128'h0);
    tbl[17] = mk(1'b1, 1'b0, A10, 32'h0, 1'b0, F_RDY,  1'b0, 32'h0, 1'b1, LINE_B);
    tbl[18] = mk(1'b0, 1'b0, A10, 32'h0, 1'b0, F_NONE, 1'b0, 32'h0, 1'b0, 128'h0);

    reset                      = 1'b0;
    read_from_L2d_request      = 1'b0;
    write_to_L2d_request       = 1'b0;
    write_back_to_L2d_request  = 1'b0;
    cache_L2d_memory_address   = 32'h0;
    cache_1d_write_data_to_L2d = 32'h0;
    write_back_to_L2d_data     = 128'h0;
    L3d_ready                  = 1'b0;
    write_data_to_L2d_from_L3d = LINE_A;
    write_back_to_L3d_verified = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_flags", 128'(flags_now()), 128'(F_NONE));
    chk("reset_l3_addr", 128'(cache_L3d_memory_address), 128'h0);
    chk("reset_l1_line", write_data_to_L1d_from_L2d, 128'h0);
    reset = 1'b1;

    // Cold read, refill, hit, word write, re-read of the merged line
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_flags", i), 128'(flags_now()), 128'(tbl[i].flags));
      if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), 128'(cache_L3d_memory_address), 128'(tbl[i].eaddr));
      if (tbl[i].cl) chk($sformatf("tbl%0d_line", i), write_data_to_L1d_from_L2d, tbl[i].eline);
      read_from_L2d_request      = tbl[i].rd;
      write_to_L2d_request       = tbl[i].wr;
      cache_L2d_memory_address   = tbl[i].addr;
      cache_1d_write_data_to_L2d = tbl[i].wdata;
      L3d_ready                  = tbl[i].l3r;
    end

    // Dirty eviction: same index, new tag
    cyc("ev_idle", F_NONE);
    read_from_L2d_request    = 1'b1;
    cache_L2d_memory_address = A410;
    cyc("ev_miss", F_MISS);
    cyc("ev_wb_req", F_WL3);
    chk("ev_wb_addr", 128'(cache_L3d_memory_address), 128'(A10));
    chk("ev_wb_data", write_back_to_L3d_data, LINE_B);
    cyc("ev_wb_hold", F_WL3);
    write_back_to_L3d_verified = 1'b1;
    cyc("ev_fetch", F_RL3);
    chk("ev_fetch_addr", 128'(cache_L3d_memory_address), 128'(A410));
    write_back_to_L3d_verified = 1'b0;
    write_data_to_L2d_from_L3d = LINE_C;
    L3d_ready                  = 1'b1;
    cyc("ev_fill", F_NONE);
    L3d_ready = 1'b0;
    cyc("ev_rdy", F_RDY);
    chk("ev_line", write_data_to_L1d_from_L2d, LINE_C);
    read_from_L2d_request = 1'b0;

    // Write-back beats read; held requests do not retrigger
    cyc("pr_idle", F_NONE);
    write_back_to_L2d_request = 1'b1;
    read_from_L2d_request     = 1'b1;
    cache_L2d_memory_address  = A410;
    write_back_to_L2d_data    = LINE_D;
    cyc("pr_hit", F_HIT);
    cyc("pr_wbv", F_WBV);
    cyc("pr_held1", F_NONE);
    cyc("pr_held2", F_NONE);
    write_back_to_L2d_request = 1'b0;
    read_from_L2d_request     = 1'b0;
    cyc("pr_idle2", F_NONE);
    read_from_L2d_request = 1'b1;
    cyc("pr_rehit", F_HIT);
    cyc("pr_rdy", F_RDY);
    chk("pr_line", write_data_to_L1d_from_L2d, LINE_D);
    read_from_L2d_request = 1'b0;

    // Write-back into an empty line installs without touching L3
    cyc("wbm_idle", F_NONE);
    write_back_to_L2d_request = 1'b1;
    cache_L2d_memory_address  = A820;
    write_back_to_L2d_data    = LINE_E;
    cyc("wbm_miss", F_MISS);
    cyc("wbm_wbv", F_WBV);
    write_back_to_L2d_request = 1'b0;
    cyc("wbm_idle2", F_NONE);
    read_from_L2d_request = 1'b1;
    cyc("wbm_hit", F_HIT);
    cyc("wbm_rdy", F_RDY);
    chk("wbm_line", write_data_to_L1d_from_L2d, LINE_E);
    read_from_L2d_request = 1'b0;

    // Reset during ALLOCATE, with a concurrent L3 pulse
    cyc("rs_idle", F_NONE);
    read_from_L2d_request    = 1'b1;
    cache_L2d_memory_address = A30;
    cyc("rs_miss", F_MISS);
    cyc("rs_fetch", F_RL3);
    chk("rs_fetch_addr", 128'(cache_L3d_memory_address), 128'(A30));
    reset                      = 1'b0;
    L3d_ready                  = 1'b1;
    write_data_to_L2d_from_L3d = LINE_A;
    #1;
    chk("rs_async_flags", 128'(flags_now()), 128'(F_NONE));
    chk("rs_async_addr", 128'(cache_L3d_memory_address), 128'h0);
    chk("rs_async_l1", write_data_to_L1d_from_L2d, 128'h0);
    chk("rs_async_wbdata", write_back_to_L3d_data, 128'h0);
    cyc("rs_hold", F_NONE);
    reset     = 1'b1;
    L3d_ready = 1'b0;
    cyc("rs_remiss", F_MISS);
    cyc("rs_refetch", F_RL3);
    read_from_L2d_request = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
